// File: rtl/snac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snac_pkg
// Description : Shared types and constants for the DB15 joystick shift-chain
//               transmitter and its matching receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package snac_pkg;

  // Default emulated chain length: two players of twelve bits each
  localparam int c_CHAIN_LEN_DEFAULT = 24;
  localparam int c_JOY_BITS          = 12;

  // Joystick bit positions inside one player word (active-high)
  localparam int c_JOY_RIGHT = 0;
  localparam int c_JOY_LEFT  = 1;
  localparam int c_JOY_DOWN  = 2;
  localparam int c_JOY_UP    = 3;
  localparam int c_JOY_BTN_A = 4;
  localparam int c_JOY_BTN_B = 5;
  localparam int c_JOY_BTN_C = 6;
  localparam int c_JOY_BTN_D = 7;
  localparam int c_JOY_BTN_E = 8;
  localparam int c_JOY_BTN_F = 9;
  localparam int c_JOY_START = 10;
  localparam int c_JOY_BTN_L = 11;

  // Transmitter state machine
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_e;

  // Both players packed into wire order, converted to active-low line levels
  function automatic logic [2*c_JOY_BITS-1:0] joy_pair_word(
    input logic [c_JOY_BITS-1:0] p1,
    input logic [c_JOY_BITS-1:0] p2
  );
    return {~p1, ~p2};
  endfunction

endpackage
`default_nettype wire

// File: rtl/joy_db15_tx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchronizer for an asynchronous level plus a
//               registered copy for rising-edge detection. All flops reset
//               to 1 so an idle-high line produces no spurious edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      // Single synchronizer flop
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 1'b1;
        else          r_sync <= i_din;
      end
    end else begin : g_chain
      // Synchronizer chain, input enters at bit 0
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= '1;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      end
    end
  endgenerate

  assign o_level = r_sync[SYNC_STAGES-1];

  // Previous synchronized value for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b1;
    else          r_prev <= o_level;
  end

  assign o_rise = o_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/joy_db15_tx.sv
`default_nettype none
// ============================================================================
// Module      : joy_db15_tx
// Description : Emulates the DB15 joystick parallel-in/serial-out shift chain.
//               The reader pulls JOY_LOAD low to latch both players, then
//               clocks bits out on JOY_DATA with JOY_CLK rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module joy_db15_tx
  import snac_pkg::*;
#(
  parameter int CHAIN_LEN   = c_CHAIN_LEN_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  RESETn,
  input  logic                  JOY_CLK,
  input  logic                  JOY_LOAD,
  output logic                  JOY_DATA,
  input  logic [c_JOY_BITS-1:0] joy1,
  input  logic [c_JOY_BITS-1:0] joy2,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [4:0]            bit_cnt
);

  localparam int         c_PAIR_BITS = 2 * c_JOY_BITS;
  localparam logic [4:0] c_LAST_BIT  = 5'(CHAIN_LEN - 1);

  logic                   w_clk_rise;
  logic                   w_unused_clk_level;
  logic                   w_load_level;
  logic                   w_load_rise;
  logic [c_PAIR_BITS-1:0] w_pair;
  logic [CHAIN_LEN-1:0]   w_load_word;

  tx_state_e              r_state;
  logic [CHAIN_LEN-1:0]   r_sreg;
  logic                   r_joy_data;
  logic [4:0]             r_bit_cnt;
  logic                   r_frame_done;
  logic                   r_overrun;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .i_clk   (i_clk),
    .i_rst_n (RESETn),
    .i_din   (JOY_CLK),
    .o_level (w_unused_clk_level),
    .o_rise  (w_clk_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .i_clk   (i_clk),
    .i_rst_n (RESETn),
    .i_din   (JOY_LOAD),
    .o_level (w_load_level),
    .o_rise  (w_load_rise)
  );

  assign w_pair = joy_pair_word(joy1, joy2);

  // Fit the two-player word to the chain: pad idle (1) bits or keep the MSBs
  generate
    if (CHAIN_LEN > c_PAIR_BITS) begin : g_pad
      assign w_load_word = {w_pair, {(CHAIN_LEN - c_PAIR_BITS){1'b1}}};
    end else begin : g_trunc
      assign w_load_word = w_pair[c_PAIR_BITS-1 -: CHAIN_LEN];
    end
  endgenerate

  // Load/shift/done sequencer with registered outputs
  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state      <= ST_LOAD;
      r_sreg       <= '1;
      r_joy_data   <= 1'b1;
      r_bit_cnt    <= 5'd0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_joy_data   <= (r_state == ST_DONE) ? 1'b1 : r_sreg[CHAIN_LEN-1];

      if (!w_load_level) begin
        // Load held low wins over everything, including a coincident clock
        r_state   <= ST_LOAD;
        r_sreg    <= w_load_word;
        r_bit_cnt <= 5'd0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            // Snapshot stays frozen from here until the next load
            if (w_load_rise) r_state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_clk_rise) begin
              r_sreg    <= {r_sreg[CHAIN_LEN-2:0], 1'b1};
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == c_LAST_BIT) begin
                r_frame_done <= 1'b1;
                r_state      <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            // Reader clocked past the end of the chain
            if (w_clk_rise) r_overrun <= 1'b1;
          end
          default: r_state <= ST_LOAD;
        endcase
      end
    end
  end

  assign JOY_DATA   = r_joy_data;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
  assign bit_cnt    = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_joy_db15_tx
// Description : Directed self-checking bench for joy_db15_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_joy_db15_tx;

  logic        i_clk = 1'b0;
  logic        RESETn;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic [11:0] joy1;
  logic [11:0] joy2;
  logic        frame_done;
  logic        overrun;
  logic [4:0]  bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_total = 0;

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [23:0] exp_stream;   // serial bit 0 in bit 23
  } vec_t;

  vec_t vecs[5];

  joy_db15_tx #(.CHAIN_LEN(24), .SYNC_STAGES(2)) dut (
    .i_clk      (i_clk),
    .RESETn     (RESETn),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .joy1       (joy1),
    .joy2       (joy2),
    .frame_done (frame_done),
    .overrun    (overrun),
    .bit_cnt    (bit_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Count every cycle frame_done is high
  always @(posedge i_clk) begin
    if (frame_done) fd_total <= fd_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_load();
    JOY_LOAD = 1'b0;
    tick(6);
    JOY_LOAD = 1'b1;
    tick(6);
  endtask

  task automatic pulse_clk();
    JOY_CLK = 1'b1;
    tick(6);
    JOY_CLK = 1'b0;
    tick(6);
  endtask

  // Capture 24 serial bits, then give the 24th clock edge
  task automatic shift_frame(output logic [23:0] got);
    got = '0;
    got[23] = JOY_DATA;
    for (int i = 1; i < 24; i++) begin
      pulse_clk();
      got[23-i] = JOY_DATA;
    end
    pulse_clk();
  endtask

  logic [23:0] got;
  int          fd0;

  initial begin
    vecs[0] = '{j1: 12'h010, j2: 12'h000, exp_stream: 24'hFEFFFF};
    vecs[1] = '{j1: 12'hFFF, j2: 12'h000, exp_stream: 24'h000FFF};
    vecs[2] = '{j1: 12'h000, j2: 12'hFFF, exp_stream: 24'hFFF000};
    vecs[3] = '{j1: 12'hA5A, j2: 12'h3C3, exp_stream: 24'h5A5C3C};
    vecs[4] = '{j1: 12'h000, j2: 12'h000, exp_stream: 24'hFFFFFF};

    RESETn   = 1'b0;
    JOY_CLK  = 1'b0;
    JOY_LOAD = 1'b1;
    joy1     = 12'h000;
    joy2     = 12'h000;
    tick(4);

    // Reset state
    check("rst JOY_DATA",   32'(JOY_DATA),   32'd1);
    check("rst bit_cnt",    32'(bit_cnt),    32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst overrun",    32'(overrun),    32'd0);

    // Clocks before any load are ignored
    RESETn = 1'b1;
    tick(4);
    joy1 = 12'h000;
    repeat (3) pulse_clk();
    check("noload bit_cnt",  32'(bit_cnt),  32'd0);
    check("noload overrun",  32'(overrun),  32'd0);
    check("noload JOY_DATA", 32'(JOY_DATA), 32'd1);
    check("noload fd",       32'(fd_total), 32'd0);

    // Table of full frames
    for (int v = 0; v < 5; v++) begin
      joy1 = vecs[v].j1;
      joy2 = vecs[v].j2;
      fd0  = fd_total;
      do_load();
      shift_frame(got);
      check($sformatf("v%0d stream", v),     32'(got),           32'(vecs[v].exp_stream));
      check($sformatf("v%0d bit_cnt", v),    32'(bit_cnt),       32'd24);
      check($sformatf("v%0d frame_done", v), 32'(fd_total - fd0), 32'd1);
      check($sformatf("v%0d done data", v),  32'(JOY_DATA),      32'd1);
      check($sformatf("v%0d overrun", v),    32'(overrun),       32'd0);
    end

    // Edge-to-data latency: bit0=0, bit1=1, change after exactly 4 cycles
    joy1 = 12'hA5A;
    joy2 = 12'h3C3;
    do_load();
    check("lat bit0", 32'(JOY_DATA), 32'd0);
    JOY_CLK = 1'b1;
    tick(3);
    check("lat +3 cycles", 32'(JOY_DATA), 32'd0);
    tick(1);
    check("lat +4 cycles", 32'(JOY_DATA), 32'd1);
    tick(4);
    JOY_CLK = 1'b0;
    tick(6);

    // Load coincident with a clock edge at bit 10
    joy1 = 12'h800;
    joy2 = 12'h000;
    do_load();
    repeat (10) pulse_clk();
    check("coinc pre bit_cnt", 32'(bit_cnt),  32'd10);
    check("coinc pre data",    32'(JOY_DATA), 32'd1);
    JOY_LOAD = 1'b0;
    JOY_CLK  = 1'b1;
    tick(6);
    check("coinc bit_cnt",  32'(bit_cnt),  32'd0);
    check("coinc data",     32'(JOY_DATA), 32'd0);
    check("coinc overrun",  32'(overrun),  32'd0);
    JOY_CLK = 1'b0;
    tick(3);
    JOY_LOAD = 1'b1;
    tick(6);
    fd0 = fd_total;
    shift_frame(got);
    check("coinc stream", 32'(got),            32'h7FFFFF);
    check("coinc fd",     32'(fd_total - fd0), 32'd1);

    // Reset mid-frame at bit 5
    joy1 = 12'h040;
    joy2 = 12'h000;
    fd0  = fd_total;
    do_load();
    repeat (5) pulse_clk();
    check("midrst pre data", 32'(JOY_DATA), 32'd0);
    RESETn = 1'b0;
    #1;
    check("midrst data",    32'(JOY_DATA), 32'd1);
    check("midrst bit_cnt", 32'(bit_cnt),  32'd0);
    tick(3);
    RESETn = 1'b1;
    tick(4);
    check("midrst no fd", 32'(fd_total - fd0), 32'd0);
    fd0 = fd_total;
    do_load();
    shift_frame(got);
    check("midrst stream", 32'(got),            32'hFBFFFF);
    check("midrst fd",     32'(fd_total - fd0), 32'd1);

    // Inputs change after load release: snapshot must hold
    joy1 = 12'h321;
    joy2 = 12'h654;
    do_load();
    joy1 = 12'hFFF;
    joy2 = 12'h000;
    shift_frame(got);
    check("snap stream", 32'(got), 32'hCDE9AB);

    // Overrun: two extra edges after a full frame
    joy1 = 12'h010;
    joy2 = 12'h000;
    do_load();
    shift_frame(got);
    check("ovr pre", 32'(overrun), 32'd0);
    fd0 = fd_total;
    repeat (2) pulse_clk();
    check("ovr data",    32'(JOY_DATA),       32'd1);
    check("ovr flag",    32'(overrun),        32'd1);
    check("ovr bit_cnt", 32'(bit_cnt),        32'd24);
    check("ovr no fd",   32'(fd_total - fd0), 32'd0);
    do_load();
    check("ovr sticky", 32'(overrun), 32'd1);
    RESETn = 1'b0;
    tick(2);
    check("ovr cleared", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
